axil_slave_regfile: RTL and testbench
=====================================

Name: axil_slave_regfile

Overview:
- AXI4-Lite responder: a bank of NUM_REGS 32-bit read/write control registers.
- It is the target end of the AXI-Lite link that the master VIP stimulus drives inside `chip`.
- It replaces the passthrough/slave VIP memory model with synthesizable RTL.
- Register contents go to downstream logic as a flat bus, with per-register write strobes.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (2..256).
- ADDR_W, 12, AXI address width; must satisfy NUM_REGS*4 <= 2**ADDR_W.
- RST_VAL, 32'h0000_0000, reset value of every register.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_W  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- reg_q  out  NUM_REGS*32  register contents; reg i occupies bits [32i+31:32i].
- reg_wr_stb  out  NUM_REGS  one-cycle pulse when register i is written.

Behaviour:
- Reset, applied on any edge with reset=1:
  - all registers = RST_VAL.
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; reg_wr_stb = 0.
  - AW/W hold flags cleared.
  - Any in-flight transaction is dropped with no response.
- All outputs are registered.
- Decode: index = addr[ADDR_W-1:2]; addr[1:0] ignored. index >= NUM_REGS is out of range.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = ~aw_held, wready = ~w_held.
  - AW and W are accepted independently, in either order or in the same cycle. Each accepted beat is latched and its ready drops the next cycle.
  - Commit occurs on the edge where the second of AW/W handshakes (or both together). On that edge:
    - in range: bytes with wstrb[k]=1 are written into reg[index]; reg_wr_stb[index]=1 for exactly one cycle; bresp=2'b00 (OKAY).
    - out of range: no write, no strobe, bresp=2'b10 (SLVERR).
    - bvalid=1; state goes to W_RESP.
  - wstrb=0 and in range: OKAY, register unchanged, strobe still pulses.
  - W_RESP: awready=wready=0. bvalid and bresp are held until bready=1. On the bvalid&bready edge: bvalid=0, hold flags cleared, awready=wready=1, state goes to W_IDLE.
  - Latency: bvalid is visible the cycle after commit. With bready tied high, back-to-back writes sustain one write per 2 cycles.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready=1. On the arvalid&arready edge:
    - in range: rdata = reg[index], rresp = OKAY.
    - out of range: rdata = 0, rresp = SLVERR.
    - rvalid=1; arready=0; state goes to R_RESP.
  - R_RESP: rdata, rresp and rvalid are held until rready=1. On that edge: rvalid=0, arready=1, state goes to R_IDLE.
  - Read latency is 1 cycle.
- Read and write FSMs run concurrently.
- Same-edge read capture and write commit to the same register: the read returns the pre-write value. The new value is visible to any read accepted later.
- reg_q reflects a write on the cycle after commit, i.e. the same cycle bvalid rises.
- VALID is never dropped or altered by the block while awaiting READY. Master-side VALID deassertion without handshake is ignored (nothing is latched).
- reset=1 while bvalid or rvalid is pending: both valids are 0 the next cycle and registers return to RST_VAL.

Test Plan:
- Write 0x12345678 to 0x008 with wstrb=4'hF, then read 0x008. Expect bresp=00, reg_wr_stb[2] pulses once, rdata=0x12345678, rresp=00, and rvalid one cycle after the AR handshake.
- Partial strobe: reg 3 = 0xAABBCCDD, then write 0x11223344 with wstrb=4'b0101. Expect readback 0xAA22CC44.
- W presented 3 cycles before AW on address 0x004, with data 0xCAFEF00D. Expect wready to drop after W acceptance, no commit until AW arrives, then bvalid the next cycle and reg 1 = 0xCAFEF00D.
- Out of range with NUM_REGS=16:
  - write 0x040: bresp=10, no reg_wr_stb bit set, reg_q unchanged.
  - read 0x3FC: rresp=10, rdata=0.
- Backpressure and collision:
  - Hold bready=0 and rready=0 for 5 cycles: bvalid/rvalid and their payloads stay stable; awready, wready and arready stay 0.
  - Read of reg 0 captured on the same edge as a write of 0x5 to reg 0 commits: the read returns the old 0x0.
- Reset mid-operation: assert reset while bvalid=1 and rvalid=1. Next cycle: bvalid=rvalid=0, all reg_q = RST_VAL, and awready = wready = arready = 1.

Source files
------------

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI4-Lite register file responder
// Ports: aclk/reset (sync, active-high); AXI-Lite AW/W/B/AR/R slave channels (s_*);
//        reg_q = flat register contents (reg i at [32i+31:32i]);
//        reg_wr_stb = one-cycle pulse per register on each committed write.
module axil_slave_regfile #(
   parameter int          NUM_REGS = 16,
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
   input  logic                     aclk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        s_awaddr,
   input  logic                     s_awvalid,
   output logic                     s_awready,
   input  logic [31:0]              s_wdata,
   input  logic [3:0]               s_wstrb,
   input  logic                     s_wvalid,
   output logic                     s_wready,
   output logic [1:0]               s_bresp,
   output logic                     s_bvalid,
   input  logic                     s_bready,
   input  logic [ADDR_W-1:0]        s_araddr,
   input  logic                     s_arvalid,
   output logic                     s_arready,
   output logic [31:0]              s_rdata,
   output logic [1:0]               s_rresp,
   output logic                     s_rvalid,
   input  logic                     s_rready,
   output logic [NUM_REGS*32-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_stb
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

   logic [31:0] regs [NUM_REGS];

   // Byte-offset bits carry no meaning for 32-bit registers.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

   // ---------------- write path ----------------
   w_state_t            w_state, w_state_next;
   logic                aw_held, w_held;
   logic [IDX_W-1:0]    aw_idx_q;
   logic [31:0]         wdata_q;
   logic [3:0]          wstrb_q;

   logic                aw_hs, w_hs, aw_have, w_have, w_commit, w_in_range;
   logic [IDX_W-1:0]    w_idx;
   logic [31:0]         w_data;
   logic [3:0]          w_strb;
   logic [NUM_REGS-1:0] w_onehot;

   logic                awready_n, wready_n, bvalid_n, aw_held_n, w_held_n;
   logic [1:0]          bresp_n;
   logic [NUM_REGS-1:0] stb_n;

   // ---------------- read path ----------------
   r_state_t            r_state, r_state_next;
   logic                ar_hs, r_in_range;
   logic [IDX_W-1:0]    r_idx;
   logic [31:0]         r_sel;
   logic                arready_n, rvalid_n;
   logic [31:0]         rdata_n;
   logic [1:0]          rresp_n;

   // Decode: a beat arriving this cycle takes precedence over an empty hold slot.
   always_comb begin
      aw_hs      = s_awvalid & s_awready;
      w_hs       = s_wvalid & s_wready;
      aw_have    = aw_held | aw_hs;
      w_have     = w_held | w_hs;
      w_idx      = aw_hs ? s_awaddr[ADDR_W-1:2] : aw_idx_q;
      w_data     = w_hs ? s_wdata : wdata_q;
      w_strb     = w_hs ? s_wstrb : wstrb_q;
      w_commit   = (w_state == W_IDLE) & aw_have & w_have;
      w_onehot   = '0;
      w_in_range = 1'b0;
      ar_hs      = s_arvalid & s_arready;
      r_idx      = s_araddr[ADDR_W-1:2];
      r_in_range = 1'b0;
      r_sel      = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == IDX_W'(i)) begin
            w_onehot[i] = 1'b1;
            w_in_range  = 1'b1;
         end
         if (r_idx == IDX_W'(i)) begin
            r_in_range = 1'b1;
            r_sel      = regs[i];
         end
      end
   end

   // Write FSM next state
   always_comb begin
      w_state_next = w_state;
      case (w_state)
         W_IDLE: if (w_commit) w_state_next = W_RESP;
         W_RESP: if (s_bready) w_state_next = W_IDLE;
      endcase
   end

   // Write FSM outputs (next values of the registered outputs)
   always_comb begin
      awready_n = s_awready;
      wready_n  = s_wready;
      bvalid_n  = s_bvalid;
      bresp_n   = s_bresp;
      aw_held_n = aw_held;
      w_held_n  = w_held;
      stb_n     = '0;
      case (w_state)
         W_IDLE: begin
            aw_held_n = aw_have;
            w_held_n  = w_have;
            awready_n = ~aw_have;
            wready_n  = ~w_have;
            if (w_commit) begin
               bvalid_n = 1'b1;
               bresp_n  = w_in_range ? RESP_OKAY : RESP_SLVERR;
               stb_n    = w_in_range ? w_onehot : '0;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               bvalid_n  = 1'b0;
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               awready_n = 1'b1;
               wready_n  = 1'b1;
            end
         end
      endcase
   end

   // Read FSM next state
   always_comb begin
      r_state_next = r_state;
      case (r_state)
         R_IDLE: if (ar_hs) r_state_next = R_RESP;
         R_RESP: if (s_rready) r_state_next = R_IDLE;
      endcase
   end

   // Read FSM outputs; regs are sampled before this edge's write lands,
   // so a same-edge collision returns the old value.
   always_comb begin
      arready_n = s_arready;
      rvalid_n  = s_rvalid;
      rdata_n   = s_rdata;
      rresp_n   = s_rresp;
      case (r_state)
         R_IDLE: begin
            if (ar_hs) begin
               arready_n = 1'b0;
               rvalid_n  = 1'b1;
               rdata_n   = r_in_range ? r_sel : 32'h0;
               rresp_n   = r_in_range ? RESP_OKAY : RESP_SLVERR;
            end
         end
         R_RESP: begin
            if (s_rready) begin
               rvalid_n  = 1'b0;
               arready_n = 1'b1;
            end
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge aclk) begin
      if (reset) begin
         w_state    <= W_IDLE;
         r_state    <= R_IDLE;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         aw_idx_q   <= '0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         s_awready  <= 1'b1;
         s_wready   <= 1'b1;
         s_bvalid   <= 1'b0;
         s_bresp    <= RESP_OKAY;
         s_arready  <= 1'b1;
         s_rvalid   <= 1'b0;
         s_rdata    <= 32'h0;
         s_rresp    <= RESP_OKAY;
         reg_wr_stb <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      end else begin
         w_state    <= w_state_next;
         r_state    <= r_state_next;
         aw_held    <= aw_held_n;
         w_held     <= w_held_n;
         if (aw_hs) aw_idx_q <= s_awaddr[ADDR_W-1:2];
         if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
         end
         s_awready  <= awready_n;
         s_wready   <= wready_n;
         s_bvalid   <= bvalid_n;
         s_bresp    <= bresp_n;
         s_arready  <= arready_n;
         s_rvalid   <= rvalid_n;
         s_rdata    <= rdata_n;
         s_rresp    <= rresp_n;
         reg_wr_stb <= stb_n;
         for (int i = 0; i < NUM_REGS; i++)
            for (int k = 0; k < 4; k++)
               if (stb_n[i] && w_strb[k]) regs[i][8*k +: 8] <= w_data[8*k +: 8];
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[32*g +: 32] = regs[g];
   end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - directed self-checking bench for axil_slave_regfile
module tb_axil_slave_regfile;

   localparam int NR = 16;
   localparam int AW = 12;

   logic           aclk, reset;
   logic [AW-1:0]  s_awaddr, s_araddr;
   logic           s_awvalid, s_awready, s_wvalid, s_wready;
   logic [31:0]    s_wdata, s_rdata;
   logic [3:0]     s_wstrb;
   logic [1:0]     s_bresp, s_rresp;
   logic           s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
   logic [NR*32-1:0] reg_q;
   logic [NR-1:0]  reg_wr_stb;

   int total = 0;
   int bad   = 0;

   axil_slave_regfile #(.NUM_REGS(NR), .ADDR_W(AW), .RST_VAL(32'h0)) dut (
      .aclk(aclk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [NR-1:0] stb);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int n = 0;
      s_awaddr = a; s_wdata = d; s_wstrb = s;
      s_awvalid = 1; s_wvalid = 1; s_bready = 0;
      while (!(aw_done && w_done) && n < 20) begin
         aw_fire = s_awvalid && s_awready;
         w_fire  = s_wvalid && s_wready;
         tick(); n++;
         if (aw_fire) begin aw_done = 1; s_awvalid = 0; end
         if (w_fire)  begin w_done = 1;  s_wvalid = 0;  end
      end
      stb = reg_wr_stb;
      resp = s_bresp;
      total++;
      if (!(aw_done && w_done && s_bvalid)) begin
         bad++; $display("FAIL write_timeout: bvalid=%0b required 1", s_bvalid);
         s_awvalid = 0; s_wvalid = 0;
      end
      s_bready = 1; tick(); s_bready = 0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit fired = 0, fire;
      int n = 0;
      s_araddr = a; s_arvalid = 1; s_rready = 0;
      while (!fired && n < 20) begin
         fire = s_arvalid && s_arready;
         tick(); n++;
         if (fire) begin fired = 1; s_arvalid = 0; end
      end
      d = s_rdata; resp = s_rresp;
      total++;
      if (!(fired && s_rvalid)) begin
         bad++; $display("FAIL read_timeout: rvalid=%0b required 1", s_rvalid);
         s_arvalid = 0;
      end
      s_rready = 1; tick(); s_rready = 0;
   endtask

   task automatic test_reset();
      reset = 1; tick(); tick();
      total++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100) begin
         bad++; $display("FAIL reset_hs: got %b required 11100", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
      end
      total++;
      if (reg_q !== '0 || reg_wr_stb !== '0 || s_rdata !== 32'h0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
         bad++; $display("FAIL reset_data: reg_q=%h stb=%h rdata=%h", reg_q, reg_wr_stb, s_rdata);
      end
      reset = 0; tick();
   endtask

   task automatic test_basic();
      logic [31:0] d; logic [1:0] r;
      s_awaddr = 12'h008; s_wdata = 32'h12345678; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_bready = 0;
      tick();
      s_awvalid = 0; s_wvalid = 0;
      total++;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || reg_wr_stb !== 16'h0004) begin
         bad++; $display("FAIL basic_commit: bvalid=%b bresp=%b stb=%h required 1 00 0004", s_bvalid, s_bresp, reg_wr_stb);
      end
      total++;
      if (reg_q[95:64] !== 32'h12345678 || s_awready !== 1'b0) begin
         bad++; $display("FAIL basic_regq: reg2=%h awready=%b required 12345678 0", reg_q[95:64], s_awready);
      end
      s_bready = 1; tick(); s_bready = 0;
      total++;
      if (s_bvalid !== 1'b0 || reg_wr_stb !== 16'h0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
         bad++; $display("FAIL basic_bdone: bvalid=%b stb=%h awready=%b wready=%b", s_bvalid, reg_wr_stb, s_awready, s_wready);
      end
      s_araddr = 12'h008; s_arvalid = 1; s_rready = 0;
      tick();
      s_arvalid = 0;
      total++;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'h12345678 || s_rresp !== 2'b00) begin
         bad++; $display("FAIL basic_read: rvalid=%b rdata=%h rresp=%b required 1 12345678 00", s_rvalid, s_rdata, s_rresp);
      end
      s_rready = 1; tick(); s_rready = 0;
      total++;
      if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
         bad++; $display("FAIL basic_rdone: rvalid=%b arready=%b required 0 1", s_rvalid, s_arready);
      end
      do_read(12'h00B, d, r);
      total++;
      if (d !== 32'h12345678) begin
         bad++; $display("FAIL low_bits_ignored: got %h required 12345678", d);
      end
   endtask

   task automatic test_partial();
      logic [31:0] d; logic [1:0] r; logic [NR-1:0] stb;
      do_write(12'h00C, 32'hAABBCCDD, 4'hF, r, stb);
      do_write(12'h00C, 32'h11223344, 4'b0101, r, stb);
      total++;
      if (r !== 2'b00 || stb !== 16'h0008) begin
         bad++; $display("FAIL partial_wr: bresp=%b stb=%h required 00 0008", r, stb);
      end
      do_read(12'h00C, d, r);
      total++;
      if (d !== 32'hAA22CC44 || r !== 2'b00) begin
         bad++; $display("FAIL partial_rd: got %h/%b required aa22cc44/00", d, r);
      end
      do_write(12'h00C, 32'hFFFFFFFF, 4'h0, r, stb);
      total++;
      if (r !== 2'b00 || stb !== 16'h0008) begin
         bad++; $display("FAIL zero_strb_wr: bresp=%b stb=%h required 00 0008", r, stb);
      end
      do_read(12'h00C, d, r);
      total++;
      if (d !== 32'hAA22CC44) begin
         bad++; $display("FAIL zero_strb_rd: got %h required aa22cc44", d);
      end
   endtask

   task automatic test_w_before_aw();
      s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1; s_awvalid = 0; s_bready = 0;
      tick();
      s_wvalid = 0;
      total++;
      if (s_wready !== 1'b0 || s_awready !== 1'b1 || s_bvalid !== 1'b0) begin
         bad++; $display("FAIL w_first_accept: wready=%b awready=%b bvalid=%b required 0 1 0", s_wready, s_awready, s_bvalid);
      end
      tick(); tick();
      total++;
      if (s_bvalid !== 1'b0 || reg_q[63:32] !== 32'h0 || s_wready !== 1'b0) begin
         bad++; $display("FAIL w_first_wait: bvalid=%b reg1=%h wready=%b required 0 0 0", s_bvalid, reg_q[63:32], s_wready);
      end
      s_awaddr = 12'h004; s_awvalid = 1;
      tick();
      s_awvalid = 0;
      total++;
      if (s_bvalid !== 1'b1 || reg_q[63:32] !== 32'hCAFEF00D || reg_wr_stb !== 16'h0002) begin
         bad++; $display("FAIL w_first_commit: bvalid=%b reg1=%h stb=%h required 1 cafef00d 0002", s_bvalid, reg_q[63:32], reg_wr_stb);
      end
      s_bready = 1; tick(); s_bready = 0;
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; logic [1:0] r; logic [NR-1:0] stb;
      logic [NR*32-1:0] exp_q;
      exp_q = '0;
      exp_q[63:32]  = 32'hCAFEF00D;
      exp_q[95:64]  = 32'h12345678;
      exp_q[127:96] = 32'hAA22CC44;
      do_write(12'h040, 32'hDEADBEEF, 4'hF, r, stb);
      total++;
      if (r !== 2'b10 || stb !== 16'h0) begin
         bad++; $display("FAIL oor_write: bresp=%b stb=%h required 10 0000", r, stb);
      end
      total++;
      if (reg_q !== exp_q) begin
         bad++; $display("FAIL oor_regq: got %h required %h", reg_q, exp_q);
      end
      do_read(12'h3FC, d, r);
      total++;
      if (d !== 32'h0 || r !== 2'b10) begin
         bad++; $display("FAIL oor_read: got %h/%b required 00000000/10", d, r);
      end
   endtask

   task automatic test_backpressure();
      s_awaddr = 12'h010; s_wdata = 32'h0BADBEEF; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_araddr = 12'h004; s_arvalid = 1;
      s_bready = 0; s_rready = 0;
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      for (int c = 0; c < 5; c++) begin
         total++;
         if ({s_bvalid, s_bresp, s_rvalid, s_rresp, s_awready, s_wready, s_arready} !== 9'b1_00_1_00_000
             || s_rdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL bp_hold cycle %0d: b=%b/%b r=%b/%b/%h rdy=%b%b%b", c, s_bvalid, s_bresp,
                            s_rvalid, s_rresp, s_rdata, s_awready, s_wready, s_arready);
         end
         tick();
      end
      s_bready = 1; s_rready = 1;
      tick();
      s_bready = 0; s_rready = 0;
      total++;
      if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00111 || reg_q[159:128] !== 32'h0BADBEEF) begin
         bad++; $display("FAIL bp_release: got %b reg4=%h required 00111 0badbeef",
                         {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, reg_q[159:128]);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d; logic [1:0] r;
      s_awaddr = 12'h000; s_wdata = 32'h5; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_araddr = 12'h000; s_arvalid = 1;
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      total++;
      if (s_rdata !== 32'h0 || s_rvalid !== 1'b1 || reg_q[31:0] !== 32'h5 || reg_wr_stb !== 16'h0001) begin
         bad++; $display("FAIL collision: rdata=%h rvalid=%b reg0=%h stb=%h required 0 1 5 0001", s_rdata, s_rvalid, reg_q[31:0], reg_wr_stb);
      end
      s_bready = 1; s_rready = 1; tick(); s_bready = 0; s_rready = 0;
      do_read(12'h000, d, r);
      total++;
      if (d !== 32'h5) begin
         bad++; $display("FAIL collision_after: got %h required 00000005", d);
      end
   endtask

   task automatic test_back_to_back();
      s_awaddr = 12'h014; s_wdata = 32'h55; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_bready = 1;
      tick();
      total++;
      if (s_bvalid !== 1'b1 || reg_wr_stb !== 16'h0020) begin
         bad++; $display("FAIL b2b_first: bvalid=%b stb=%h required 1 0020", s_bvalid, reg_wr_stb);
      end
      s_awaddr = 12'h018; s_wdata = 32'h66;
      tick();
      total++;
      if (s_bvalid !== 1'b0 || reg_wr_stb !== 16'h0 || s_awready !== 1'b1) begin
         bad++; $display("FAIL b2b_gap: bvalid=%b stb=%h awready=%b required 0 0000 1", s_bvalid, reg_wr_stb, s_awready);
      end
      tick();
      s_awvalid = 0; s_wvalid = 0;
      total++;
      if (s_bvalid !== 1'b1 || reg_wr_stb !== 16'h0040 || reg_q[223:192] !== 32'h66 || reg_q[191:160] !== 32'h55) begin
         bad++; $display("FAIL b2b_second: bvalid=%b stb=%h reg6=%h reg5=%h", s_bvalid, reg_wr_stb, reg_q[223:192], reg_q[191:160]);
      end
      tick();
      s_bready = 0;
   endtask

   task automatic test_reset_mid();
      s_awaddr = 12'h008; s_wdata = 32'h77; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_araddr = 12'h008; s_arvalid = 1;
      s_bready = 0; s_rready = 0;
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      total++;
      if (s_bvalid !== 1'b1 || s_rvalid !== 1'b1) begin
         bad++; $display("FAIL rst_mid_setup: bvalid=%b rvalid=%b required 1 1", s_bvalid, s_rvalid);
      end
      reset = 1;
      tick();
      total++;
      if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00111) begin
         bad++; $display("FAIL rst_mid_hs: got %b required 00111", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready});
      end
      total++;
      if (reg_q !== '0 || reg_wr_stb !== '0) begin
         bad++; $display("FAIL rst_mid_regs: reg_q=%h stb=%h required 0", reg_q, reg_wr_stb);
      end
      reset = 0;
      tick();
   endtask

   initial begin
      reset = 1;
      s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
      s_araddr = '0; s_arvalid = 0; s_rready = 0;
      test_reset();
      test_basic();
      test_partial();
      test_w_before_aw();
      test_out_of_range();
      test_backpressure();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
